// File: rtl/bus_slave_demux.sv
// Single-master to NS-slave request demultiplexer with in-order response return.
// Requests that decode to no slave are answered by an internal bus-error responder.
module bus_slave_demux #(
    parameter int unsigned NS       = 8,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 38,
    parameter int unsigned RW       = 32,
    parameter int unsigned LGMAXOUT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_stall,
    input  logic [NS:0]      i_decode,
    input  logic [AW-1:0]    i_addr,
    input  logic [DW-1:0]    i_data,
    output logic [NS-1:0]    o_svalid,
    input  logic [NS-1:0]    i_sstall,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    input  logic [NS-1:0]    i_sack,
    input  logic [NS-1:0]    i_serr,
    input  logic [NS*RW-1:0] i_srdata,
    output logic             o_ack,
    output logic             o_err,
    output logic [RW-1:0]    o_rdata,
    output logic             o_busy
);

    localparam int unsigned SW = $clog2(NS + 1);
    localparam logic [LGMAXOUT-1:0] MAXOUT = {LGMAXOUT{1'b1}};
    localparam logic [SW-1:0] NOSLAVE = SW'(NS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    state_t                state_next;
    logic [LGMAXOUT-1:0]   cnt;
    logic [LGMAXOUT-1:0]   cnt_next;
    logic [SW-1:0]         r_sel;
    logic [SW-1:0]         sel;
    logic                  err_pend;
    logic                  accept;
    logic                  ret;
    logic                  ret_err;
    logic                  held_stall;
    logic [RW-1:0]         srdata_sel;

    // Lowest set decode bit wins; an empty decode falls through to the error responder
    always_comb begin
        sel = NOSLAVE;
        for (int k = int'(NS) - 1; k >= 0; k--) begin
            if (i_decode[k]) begin
                sel = SW'(k);
            end
        end
    end

    // Stall, accept, return-event and next-state logic
    always_comb begin
        held_stall = 1'b0;
        o_stall    = 1'b0;
        accept     = 1'b0;
        ret        = 1'b0;
        ret_err    = 1'b0;
        srdata_sel = '0;
        cnt_next   = cnt;
        state_next = state;

        held_stall = |(o_svalid & i_sstall);
        o_stall    = held_stall
                   || (i_valid && (state == ACTIVE) && (sel != r_sel))
                   || (cnt == MAXOUT);
        accept     = i_valid && !o_stall;

        if (r_sel == NOSLAVE) begin
            ret     = err_pend;
            ret_err = 1'b1;
        end else begin
            for (int k = 0; k < int'(NS); k++) begin
                if (r_sel == SW'(k)) begin
                    ret        = i_sack[k] && (cnt != '0);
                    ret_err    = i_serr[k];
                    srdata_sel = i_srdata[k*RW +: RW];
                end
            end
        end

        cnt_next = cnt + LGMAXOUT'(accept) - LGMAXOUT'(ret);

        case (state)
            IDLE:    if (accept) state_next = ACTIVE;
            ACTIVE:  if (cnt_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request register, outstanding counter and response register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt      <= '0;
            r_sel    <= '0;
            err_pend <= 1'b0;
            o_svalid <= '0;
            o_saddr  <= '0;
            o_sdata  <= '0;
            o_ack    <= 1'b0;
            o_err    <= 1'b0;
            o_rdata  <= '0;
        end else begin
            cnt      <= cnt_next;
            err_pend <= accept && (sel == NOSLAVE);

            if (accept) begin
                r_sel <= sel;
                if (sel != NOSLAVE) begin
                    o_svalid <= NS'(1) << sel;
                    o_saddr  <= i_addr;
                    o_sdata  <= i_data;
                end else begin
                    o_svalid <= '0;
                end
            end else if (!held_stall) begin
                o_svalid <= '0;
            end

            o_ack <= ret && !ret_err;
            o_err <= ret && ret_err;
            if (ret) begin
                o_rdata <= srdata_sel;
            end
        end
    end

    assign o_busy = (state == ACTIVE);

endmodule

// File: tb/tb_bus_slave_demux.sv
// Directed bench for bus_slave_demux: one task per scenario with inline checks.
module tb_bus_slave_demux;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic         stall;
    logic [8:0]   decode;
    logic [31:0]  addr;
    logic [37:0]  data;
    logic [7:0]   svalid;
    logic [7:0]   sstall;
    logic [31:0]  saddr;
    logic [37:0]  sdata;
    logic [7:0]   sack;
    logic [7:0]   serr;
    logic [255:0] srdata;
    logic         ack;
    logic         err;
    logic [31:0]  rdata;
    logic         busy;

    int checks;
    int errors;
    int maxc;

    bus_slave_demux dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_valid  (valid),
        .o_stall  (stall),
        .i_decode (decode),
        .i_addr   (addr),
        .i_data   (data),
        .o_svalid (svalid),
        .i_sstall (sstall),
        .o_saddr  (saddr),
        .o_sdata  (sdata),
        .i_sack   (sack),
        .i_serr   (serr),
        .i_srdata (srdata),
        .o_ack    (ack),
        .o_err    (err),
        .o_rdata  (rdata),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        valid  = 1'b0;
        decode = '0;
        addr   = '0;
        data   = '0;
        sstall = '0;
        sack   = '0;
        serr   = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_in();
        tick();
        tick();
        checks++; if (svalid !== 8'h00) begin errors++; $display("FAIL reset_svalid got %h exp %h", svalid, 8'h00); end
        checks++; if (saddr !== 32'h0) begin errors++; $display("FAIL reset_saddr got %h exp %h", saddr, 32'h0); end
        checks++; if (sdata !== 38'h0) begin errors++; $display("FAIL reset_sdata got %h exp %h", sdata, 38'h0); end
        checks++; if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ackerr got %b%b exp 00", ack, err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
        checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_busystall got %b%b exp 00", busy, stall); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        clear_in();
        valid  = 1'b1;
        decode = 9'h004;
        addr   = 32'h4000_0010;
        data   = 38'h01_2345_6789;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall got %b exp 0", stall); end
        tick();
        clear_in();
        #1;
        checks++; if (svalid !== 8'h04) begin errors++; $display("FAIL single_svalid got %h exp %h", svalid, 8'h04); end
        checks++; if (saddr !== 32'h4000_0010) begin errors++; $display("FAIL single_saddr got %h exp %h", saddr, 32'h4000_0010); end
        checks++; if (sdata !== 38'h01_2345_6789) begin errors++; $display("FAIL single_sdata got %h exp %h", sdata, 38'h01_2345_6789); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        tick();
        checks++; if (svalid !== 8'h00) begin errors++; $display("FAIL single_svalid_clr got %h exp %h", svalid, 8'h00); end
        tick();
        tick();
        sack = 8'h04;
        srdata[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_early_ack got %b exp 0", ack); end
        tick();
        sack = 8'h00;
        #1;
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL single_ack got %b%b exp 10", ack, err); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h exp %h", rdata, 32'hDEAD_BEEF); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
        tick();
        checks++; if (ack !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold got ack %b rdata %h exp 0 deadbeef", ack, rdata); end
    endtask

    task automatic test_back_to_back;
        maxc = 0;
        for (int w = 0; w < 8; w++) begin
            clear_in();
            valid  = (w < 4);
            decode = 9'h001;
            addr   = 32'h1000_0000 + 32'(w * 4);
            data   = 38'(w + 1);
            sack   = (w >= 2 && w < 6) ? 8'h01 : 8'h00;
            srdata[31:0] = 32'hA000_0000 + 32'(w - 2);
            #1;
            if (w < 4) begin
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall w%0d got %b exp 0", w, stall); end
            end
            checks++; if (svalid !== ((w >= 1 && w <= 4) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL b2b_svalid w%0d got %h", w, svalid); end
            checks++; if (ack !== (w >= 3 && w <= 6)) begin errors++; $display("FAIL b2b_ack w%0d got %b", w, ack); end
            if (w >= 3 && w <= 6) begin
                checks++; if (rdata !== 32'hA000_0000 + 32'(w - 3)) begin errors++; $display("FAIL b2b_rdata w%0d got %h exp %h", w, rdata, 32'hA000_0000 + 32'(w - 3)); end
            end
            if (w == 2) begin
                checks++; if (saddr !== 32'h1000_0004) begin errors++; $display("FAIL b2b_saddr got %h exp %h", saddr, 32'h1000_0004); end
            end
            if (int'(dut.cnt) > maxc) maxc = int'(dut.cnt);
            tick();
        end
        checks++; if (maxc != 2) begin errors++; $display("FAIL b2b_cnt_peak got %0d exp 2", maxc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_switch;
        for (int w = 0; w < 9; w++) begin
            clear_in();
            valid  = (w <= 5);
            decode = (w < 2) ? 9'h001 : 9'h002;
            addr   = (w < 2) ? 32'h0000_0100 : 32'h2000_0000;
            sack   = (w == 3 || w == 4) ? 8'h01 : ((w == 7) ? 8'h02 : 8'h00);
            srdata[63:32] = 32'h5555_1111;
            #1;
            if (w >= 2 && w <= 4) begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL switch_stall w%0d got %b exp 1", w, stall); end
            end
            if (w == 5) begin
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL switch_release got %b exp 0", stall); end
            end
            if (w == 6) begin
                checks++; if (svalid !== 8'h02) begin errors++; $display("FAIL switch_svalid got %h exp %h", svalid, 8'h02); end
                checks++; if (saddr !== 32'h2000_0000) begin errors++; $display("FAIL switch_saddr got %h exp %h", saddr, 32'h2000_0000); end
            end
            if (w == 8) begin
                checks++; if (ack !== 1'b1 || rdata !== 32'h5555_1111) begin errors++; $display("FAIL switch_resp got ack %b rdata %h exp 1 55551111", ack, rdata); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL switch_busy got %b exp 0", busy); end
            end
            tick();
        end
    endtask

    task automatic test_no_slave(input logic [8:0] dec, input string tag);
        clear_in();
        valid  = 1'b1;
        decode = dec;
        addr   = 32'hFFFF_0000;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_stall got %b exp 0", tag, stall); end
        tick();
        clear_in();
        sack = 8'hFF;
        #1;
        checks++; if (svalid !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL %s_early got svalid %h err %b exp 00 0", tag, svalid, err); end
        tick();
        sack = 8'h00;
        #1;
        checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL %s_err got err %b ack %b exp 1 0", tag, err, ack); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL %s_rdata got %h exp %h", tag, rdata, 32'h0); end
        tick();
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_end got err %b busy %b exp 0 0", tag, err, busy); end
    endtask

    task automatic test_stall_hold;
        clear_in();
        valid  = 1'b1;
        decode = 9'h008;
        addr   = 32'h3000_0030;
        data   = 38'h2A_BCDE_F012;
        sstall = 8'h08;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_first_stall got %b exp 0", stall); end
        tick();
        for (int w = 1; w <= 5; w++) begin
            addr = 32'h3000_0034;
            data = 38'h1;
            #1;
            checks++; if (svalid !== 8'h08 || saddr !== 32'h3000_0030 || sdata !== 38'h2A_BCDE_F012 || stall !== 1'b1) begin
                errors++; $display("FAIL hold_w%0d got svalid %h saddr %h sdata %h stall %b", w, svalid, saddr, sdata, stall);
            end
            tick();
        end
        sstall = 8'h00;
        for (int w = 6; w <= 20; w++) begin
            addr = 32'h3000_0100 + 32'(w);
            #1;
            checks++; if (stall !== (w == 20)) begin errors++; $display("FAIL maxout_stall w%0d got %b exp %b", w, stall, (w == 20)); end
            if (w == 20) begin
                checks++; if (dut.cnt !== 4'd15) begin errors++; $display("FAIL maxout_cnt got %0d exp 15", dut.cnt); end
            end
            tick();
        end
        clear_in();
        #1;
        checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL maxout_idle got stall %b busy %b exp 1 1", stall, busy); end
        tick();
        for (int i = 0; i < 12; i++) begin
            clear_in();
            sack = 8'h08;
            srdata[127:96] = 32'h0303_0000 + 32'(i);
            #1;
            if (i > 0) begin
                checks++; if (ack !== 1'b1 || rdata !== 32'h0303_0000 + 32'(i - 1)) begin errors++; $display("FAIL drain_%0d got ack %b rdata %h", i, ack, rdata); end
            end
            tick();
        end
        clear_in();
        #1;
        checks++; if (dut.cnt !== 4'd3 || ack !== 1'b1) begin errors++; $display("FAIL drain_end got cnt %0d ack %b exp 3 1", dut.cnt, ack); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sack  = 8'hFF;
        #1;
        checks++; if (svalid !== 8'h00 || ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_out got svalid %h ack %b err %b rdata %h", svalid, ack, err, rdata);
        end
        checks++; if (dut.cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_cnt got %0d busy %b exp 0 0", dut.cnt, busy); end
        tick();
        sack = 8'h00;
        #1;
        checks++; if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_late_ack got ack %b err %b busy %b rdata %h", ack, err, busy, rdata);
        end
        checks++; if (saddr !== 32'h0 || sdata !== 38'h0) begin errors++; $display("FAIL rstmid_bus got saddr %h sdata %h", saddr, sdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        srdata = '0;
        reset  = 1'b1;
        clear_in();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_switch();
        test_no_slave(9'h100, "noslave_bit");
        test_no_slave(9'h000, "noslave_zero");
        test_stall_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
